// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision square-root unit.
// Holds the FSM encoding, IEEE-754 constants and operand classification.
package fp_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'b000,
      ITER = 3'b001,
      PACK = 3'b010,
      DONE = 3'b011
   } fsm_state_t;

   typedef enum logic [2:0] {
      FC_ZERO,
      FC_DENORM,
      FC_INF,
      FC_NAN,
      FC_NORMAL
   } fp_class_t;

   localparam logic [8:0]  FP_BIAS   = 9'd127;
   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF   = 32'h7F80_0000;
   localparam logic [4:0]  ITER_LAST = 5'd23;

   function automatic fp_class_t classify(input logic [31:0] x);
      logic e_min;
      logic e_max;
      logic f_zero;
      e_min  = (x[30:23] == 8'h00);
      e_max  = (x[30:23] == 8'hFF);
      f_zero = (x[22:0] == 23'd0);
      unique case (1'b1)
         e_min && f_zero:  classify = FC_ZERO;
         e_min && !f_zero: classify = FC_DENORM;
         e_max && f_zero:  classify = FC_INF;
         e_max && !f_zero: classify = FC_NAN;
         default:          classify = FC_NORMAL;
      endcase
   endfunction

endpackage

// File: rtl/fsqrt_unit_if.sv
// Handshake bundle between decode/control and the square-root unit.
// The master side issues start/operand; the slave side returns the root.
interface fsqrt_unit_if;
   logic        start;
   logic [31:0] operand;
   logic [31:0] result;
   logic        result_valid;
   logic        halt_sqrt;
   logic [2:0]  fsm_state;

   modport master (
      output start, operand,
      input  result, result_valid, halt_sqrt, fsm_state
   );

   modport slave (
      input  start, operand,
      output result, result_valid, halt_sqrt, fsm_state
   );
endinterface

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root iteration, purely combinational.
// Brings in the next radicand bit pair and decides one root bit.
module isqrt_step (
   input  logic [25:0] rem_in,
   input  logic [1:0]  pair,
   input  logic [23:0] root_in,
   output logic [25:0] rem_out,
   output logic [23:0] root_out
);
   logic [25:0] acc;
   logic [25:0] trial;
   logic        ge;

   always_comb begin
      acc      = 26'({rem_in, pair});
      trial    = {root_in, 2'b01};
      ge       = (acc >= trial);
      rem_out  = ge ? (acc - trial) : acc;
      root_out = {root_in[22:0], ge};
   end
endmodule

// File: rtl/fsqrt_unit.sv
// Multi-cycle IEEE-754 single-precision square root, truncating result.
// Specials resolve in one cycle; normals take 24 root iterations plus pack.
module fsqrt_unit
   import fp_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   fsqrt_unit_if.slave  bus
);
   fsm_state_t  state_q;
   logic [4:0]  cnt_q;
   logic [47:0] rad_q;
   logic [25:0] rem_q;
   logic [23:0] root_q;
   logic [7:0]  exp_q;
   logic [31:0] result_q;

   logic [25:0] rem_nx;
   logic [23:0] root_nx;
   fp_class_t   cls;
   logic        is_special;
   logic [31:0] spec_val;
   logic [24:0] mant;
   logic [8:0]  exp_sum;
   logic [7:0]  exp_half;

   always_comb begin
      cls        = classify(bus.operand);
      is_special = 1'b1;
      spec_val   = CANON_NAN;
      unique case (cls)
         FC_ZERO, FC_DENORM: spec_val = {bus.operand[31], 31'd0};
         FC_INF:    spec_val = bus.operand[31] ? CANON_NAN : POS_INF;
         FC_NAN:    spec_val = CANON_NAN;
         default:   is_special = bus.operand[31];
      endcase
      // Even biased exponent means odd true exponent: fold one factor of 2 in
      mant = bus.operand[23] ? {2'b01, bus.operand[22:0]}
                             : {1'b1, bus.operand[22:0], 1'b0};
      exp_sum  = {1'b0, bus.operand[30:23]} + FP_BIAS;
      exp_half = 8'(exp_sum >> 1);
   end

   isqrt_step u_step (
      .rem_in   (rem_q),
      .pair     (rad_q[47:46]),
      .root_in  (root_q),
      .rem_out  (rem_nx),
      .root_out (root_nx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 5'd0;
         rad_q    <= 48'd0;
         rem_q    <= 26'd0;
         root_q   <= 24'd0;
         exp_q    <= 8'd0;
         result_q <= 32'h0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (is_special) begin
                     result_q <= spec_val;
                     state_q  <= DONE;
                  end else begin
                     cnt_q   <= ITER_LAST;
                     rad_q   <= {mant, 23'd0};
                     rem_q   <= 26'd0;
                     root_q  <= 24'd0;
                     exp_q   <= exp_half;
                     state_q <= ITER;
                  end
               end
            end
            ITER: begin
               rem_q  <= rem_nx;
               root_q <= root_nx;
               rad_q  <= {rad_q[45:0], 2'b00};
               if (cnt_q == 5'd0) begin
                  state_q <= PACK;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            PACK: begin
               result_q <= {1'b0, exp_q, root_q[22:0]};
               state_q  <= DONE;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.result       = result_q;
   assign bus.result_valid = (state_q == DONE);
   assign bus.fsm_state    = state_q;
   assign bus.halt_sqrt    = rst_n &&
                             ((state_q == IDLE && bus.start) ||
                              state_q == ITER || state_q == PACK);
endmodule
